cpu_top: RTL and testbench

// - Top level of a 5-stage in-order pipelined RV32I-subset CPU (IF, ID, EX, MEM, WB).
// - Self-contained: holds the instruction ROM, data RAM and register file, and has no external buses.
// - Only clock and reset leave the block; the bench observes state hierarchically (PC, regfile, dmem).

---
 rtl/cpu_pkg.sv | 82 ++++++++
 rtl/cpu_regfile.sv | 38 +++
 rtl/cpu_top.sv | 177 +++++++++++++++++
 tb/tb_cpu_top.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the 5-stage RV32I-subset pipeline.
// Pipeline bundles, ALU ops and bubble constants.
package cpu_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        alu_op_e     alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        reg_write;
    } mem_wb_t;

    localparam if_id_t IF_ID_NOP = '{
        instr: NOP_INSTR,
        default: '0
    };

    localparam id_ex_t ID_EX_NOP = '{
        instr:  NOP_INSTR,
        alu_op: ALU_ADD,
        default: '0
    };

    localparam ex_mem_t EX_MEM_NOP = '0;
    localparam mem_wb_t MEM_WB_NOP = '0;

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 register file, two async read ports, one write port.
// x0 is hardwired to zero; a same-cycle write is bypassed to reads.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs [32];

    // register state, cleared on reset, x0 never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

    // read ports with write-through bypass
    always_comb begin
        rd1 = regs[ra1];
        rd2 = regs[ra2];
        if (we && wa == ra1) rd1 = wd;
        if (we && wa == ra2) rd2 = wd;
        if (ra1 == 5'd0) rd1 = '0;
        if (ra2 == 5'd0) rd2 = '0;
    end

endmodule

// File: rtl/cpu_top.sv
// 5-stage in-order RV32I-subset CPU with internal ROM and RAM.
// Forwarding, 1-cycle load-use stall, BEQ resolved in EX.
module cpu_top
    import cpu_pkg::*;
#(
    parameter int    IMEM_DEPTH = 64,
    parameter int    DMEM_DEPTH = 64,
    parameter string IMEM_INIT  = "program.hex"
) (
    input logic clk,
    input logic rst_n
);

    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];

    logic [31:0] pc;
    if_id_t      if_id;
    id_ex_t      id_ex, dec;
    ex_mem_t     ex_mem, ex_nxt;
    mem_wb_t     mem_wb, mem_nxt;

    logic [31:0] rf_rd1, rf_rd2;
    logic        stall, take;
    logic [31:0] target;
    logic [31:0] opa, opb, alu_b, alu_y;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] ins;

    assign ins = if_id.instr;
    assign opc = ins[6:0];
    assign f3  = ins[14:12];
    assign f7  = ins[31:25];

    cpu_regfile u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (ins[19:15]),
        .ra2   (ins[24:20]),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2),
        .we    (mem_wb.reg_write),
        .wa    (mem_wb.rd),
        .wd    (mem_wb.wdata)
    );

    // decode the instruction in ID into an ID/EX bundle
    always_comb begin
        dec       = ID_EX_NOP;
        dec.pc    = if_id.pc;
        dec.instr = ins;
        dec.rs1   = ins[19:15];
        dec.rs2   = ins[24:20];
        dec.rd    = ins[11:7];
        dec.rs1v  = rf_rd1;
        dec.rs2v  = rf_rd2;
        unique case (1'b1)
            opc == OP_R: begin
                dec.reg_write = 1'b1;
                unique case (1'b1)
                    f3 == F3_ADD && f7 == F7_BASE: dec.alu_op = ALU_ADD;
                    f3 == F3_ADD && f7 == F7_SUB:  dec.alu_op = ALU_SUB;
                    f3 == F3_AND && f7 == F7_BASE: dec.alu_op = ALU_AND;
                    f3 == F3_OR  && f7 == F7_BASE: dec.alu_op = ALU_OR;
                    f3 == F3_SLT && f7 == F7_BASE: dec.alu_op = ALU_SLT;
                    default: dec.reg_write = 1'b0;
                endcase
            end
            opc == OP_I && f3 == F3_ADD: begin
                dec.imm       = {{20{ins[31]}}, ins[31:20]};
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            opc == OP_LW && f3 == F3_W: begin
                dec.imm       = {{20{ins[31]}}, ins[31:20]};
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
            end
            opc == OP_SW && f3 == F3_W: begin
                dec.imm       = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            opc == OP_BR && f3 == F3_BEQ: begin
                dec.imm    = {{19{ins[31]}}, ins[31], ins[7],
                              ins[30:25], ins[11:8], 1'b0};
                dec.branch = 1'b1;
            end
            default: ;
        endcase
    end

    // load-use hazard on the instruction sitting in ID
    assign stall = id_ex.mem_read && id_ex.rd != 5'd0 &&
                   (id_ex.rd == dec.rs1 || id_ex.rd == dec.rs2);

    // operand forwarding, EX/MEM first, then MEM/WB
    always_comb begin
        opa = id_ex.rs1v;
        opb = id_ex.rs2v;
        if (ex_mem.reg_write && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs1)
            opa = ex_mem.alu;
        else if (mem_wb.reg_write && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs1)
            opa = mem_wb.wdata;
        if (ex_mem.reg_write && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs2)
            opb = ex_mem.alu;
        else if (mem_wb.reg_write && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs2)
            opb = mem_wb.wdata;
    end

    assign alu_b  = id_ex.alu_src ? id_ex.imm : opb;
    assign take   = id_ex.branch && (opa == opb);
    assign target = id_ex.pc + id_ex.imm;

    // ALU
    always_comb begin
        unique case (id_ex.alu_op)
            ALU_SUB: alu_y = opa - alu_b;
            ALU_AND: alu_y = opa & alu_b;
            ALU_OR:  alu_y = opa | alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(opa) < $signed(alu_b)};
            default: alu_y = opa + alu_b;
        endcase
    end

    // EX/MEM and MEM/WB next-state bundles
    always_comb begin
        ex_nxt.alu       = alu_y;
        ex_nxt.sdata     = opb;
        ex_nxt.rd        = id_ex.rd;
        ex_nxt.reg_write = id_ex.reg_write;
        ex_nxt.mem_read  = id_ex.mem_read;
        ex_nxt.mem_write = id_ex.mem_write;
        mem_nxt.rd        = ex_mem.rd;
        mem_nxt.reg_write = ex_mem.reg_write;
        mem_nxt.wdata     = ex_mem.mem_read ?
                            dmem[ex_mem.alu[DW+1:2]] : ex_mem.alu;
    end

    // PC and pipeline registers; a taken branch overrides a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= '0;
            if_id  <= IF_ID_NOP;
            id_ex  <= ID_EX_NOP;
            ex_mem <= EX_MEM_NOP;
            mem_wb <= MEM_WB_NOP;
        end else begin
            ex_mem <= ex_nxt;
            mem_wb <= mem_nxt;
            if (take) begin
                pc    <= target;
                if_id <= IF_ID_NOP;
                id_ex <= ID_EX_NOP;
            end else if (stall) begin
                id_ex <= ID_EX_NOP;
            end else begin
                pc    <= pc + 32'd4;
                if_id <= '{pc: pc, instr: imem[pc[IW+1:2]]};
                id_ex <= dec;
            end
        end
    end

    // data RAM write port
    always_ff @(posedge clk) begin
        if (ex_mem.mem_write) dmem[ex_mem.alu[DW+1:2]] <= ex_mem.sdata;
    end

endmodule

// File: tb/tb_cpu_top.sv
// Directed-program bench for cpu_top.
// Programs are placed in the ROM hierarchically during reset.
module tb_cpu_top;

    logic clk;
    logic rst_n;

    int nchk;
    int nerr;
    int stalls;

    logic [31:0] prog [8];
    int          plen;

    cpu_top dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && dut.stall) stalls++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] e_addi(input logic [4:0] rd,
                                           input logic [4:0] rs1,
                                           input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction

    function automatic logic [31:0] e_r(input logic [6:0] f7,
                                        input logic [2:0] f3,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs1,
                                        input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] e_lw(input logic [4:0] rd,
                                         input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'h03};
    endfunction

    function automatic logic [31:0] e_sw(input logic [4:0] rs2,
                                         input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] e_beq(input logic [4:0] rs1,
                                          input logic [4:0] rs2,
                                          input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000,
                imm[4:1], imm[11], 7'h63};
    endfunction

    task automatic start();
        rst_n  = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) begin
            dut.imem[i] = (i < plen) ? prog[i] : 32'h00000013;
            dut.dmem[i] = 32'd0;
        end
        stalls = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rg(input int k);
        return dut.u_rf.regs[k];
    endfunction

    initial begin
        nchk  = 0;
        nerr  = 0;
        rst_n = 1'b0;

        // ALU + forwarding program, also used for reset checks
        prog[0] = e_addi(5'd1, 5'd0, 12'd5);
        prog[1] = e_addi(5'd2, 5'd1, 12'd3);
        prog[2] = e_r(7'h00, 3'b000, 5'd3, 5'd1, 5'd2);
        prog[3] = e_r(7'h20, 3'b000, 5'd4, 5'd3, 5'd1);
        plen = 4;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) begin
            dut.imem[i] = (i < plen) ? prog[i] : 32'h00000013;
            dut.dmem[i] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", dut.pc, 32'd0);
        check("rst_x1", rg(1), 32'd0);
        check("rst_x31", rg(31), 32'd0);
        check("rst_ifid", dut.if_id.instr, 32'h00000013);
        check("rst_idex", dut.id_ex.instr, 32'h00000013);
        check("rst_ctl", {31'd0, dut.id_ex.reg_write | dut.ex_mem.reg_write
                          | dut.mem_wb.reg_write | dut.ex_mem.mem_write}, 32'd0);
        @(negedge clk);
        stalls = 0;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        check("pc_first", dut.pc, 32'd4);
        repeat (3) @(posedge clk);
        #1;
        check("x1_before_wb", rg(1), 32'd0);
        @(posedge clk);
        #1;
        check("x1_at_wb", rg(1), 32'd5);
        repeat (10) @(posedge clk);
        #1;
        check("alu_x1", rg(1), 32'd5);
        check("alu_x2", rg(2), 32'd8);
        check("alu_x3", rg(3), 32'd13);
        check("alu_x4", rg(4), 32'd8);
        check("alu_stalls", stalls, 32'd0);

        // load-use
        prog[0] = e_addi(5'd1, 5'd0, 12'd7);
        prog[1] = e_sw(5'd1, 5'd0, 12'd0);
        prog[2] = e_lw(5'd2, 5'd0, 12'd0);
        prog[3] = e_r(7'h00, 3'b000, 5'd3, 5'd2, 5'd2);
        plen = 4;
        start();
        repeat (15) @(posedge clk);
        #1;
        check("ld_dmem0", dut.dmem[0], 32'd7);
        check("ld_x2", rg(2), 32'd7);
        check("ld_x3", rg(3), 32'd14);
        check("ld_stalls", stalls, 32'd1);

        // taken branch
        prog[0] = e_addi(5'd1, 5'd0, 12'd1);
        prog[1] = e_beq(5'd1, 5'd1, 13'd8);
        prog[2] = e_addi(5'd5, 5'd0, 12'd9);
        prog[3] = e_addi(5'd6, 5'd0, 12'd2);
        plen = 4;
        start();
        repeat (15) @(posedge clk);
        #1;
        check("br_x5", rg(5), 32'd0);
        check("br_x6", rg(6), 32'd2);

        // not-taken branch
        prog[1] = e_beq(5'd0, 5'd1, 13'd8);
        start();
        repeat (15) @(posedge clk);
        #1;
        check("nt_x5", rg(5), 32'd9);
        check("nt_x6", rg(6), 32'd2);

        // x0 write, SLT/AND/OR with a negative operand
        prog[0] = e_addi(5'd0, 5'd0, 12'd5);
        prog[1] = e_addi(5'd7, 5'd0, 12'hFFD);
        prog[2] = e_r(7'h00, 3'b010, 5'd8, 5'd7, 5'd0);
        prog[3] = e_r(7'h00, 3'b111, 5'd9, 5'd7, 5'd0);
        prog[4] = e_addi(5'd10, 5'd0, 12'd6);
        prog[5] = e_r(7'h00, 3'b110, 5'd11, 5'd10, 5'd7);
        prog[6] = e_r(7'h00, 3'b010, 5'd12, 5'd0, 5'd10);
        prog[7] = e_r(7'h00, 3'b111, 5'd13, 5'd7, 5'd10);
        plen = 8;
        start();
        repeat (20) @(posedge clk);
        #1;
        check("x0_zero", rg(0), 32'd0);
        check("x0_read", dut.u_rf.rd1 & 32'd0 | rg(0), 32'd0);
        check("neg_x7", rg(7), 32'hFFFFFFFD);
        check("slt_neg", rg(8), 32'd1);
        check("and_zero", rg(9), 32'd0);
        check("or_x11", rg(11), 32'hFFFFFFFF);
        check("slt_pos", rg(12), 32'd1);
        check("and_x13", rg(13), 32'd4);

        // reset mid-run
        prog[0] = e_addi(5'd1, 5'd0, 12'd5);
        prog[1] = e_addi(5'd2, 5'd1, 12'd3);
        prog[2] = e_r(7'h00, 3'b000, 5'd3, 5'd1, 5'd2);
        prog[3] = e_r(7'h20, 3'b000, 5'd4, 5'd3, 5'd1);
        plen = 4;
        start();
        repeat (6) @(posedge clk);
        #2;
        check("mid_x1_pre", rg(1), 32'd5);
        rst_n = 1'b0;
        #1;
        check("mid_pc", dut.pc, 32'd0);
        check("mid_x1", rg(1), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_x2", rg(2), 32'd0);
        check("mid_x3", rg(3), 32'd0);
        check("mid_pc_hold", dut.pc, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
